sprite_blitter: RTL
===================

Name: sprite_blitter

Overview:
- Positioned, animated sprite renderer for the VGA pipeline. It replaces the full-screen stretch-to-fit sprite examples.
- Maps DrawX/DrawY into a parametrised multi-frame sprite ROM, with sprite position, power-of-two scaling, horizontal/vertical flip and a palette-index transparency key.
- A frame-tick-driven animation FSM (loop or one-shot) selects the frame.
- Output is palette index plus coverage flag, consumed by the colour mapper/compositor.

Parameters:
- SPR_W, 24, sprite width in texels.
- SPR_H, 24, sprite height in texels.
- N_FRAMES, 4, animation frames stored back-to-back in the ROM.
- SCALE_SH, 0, scale = 2^SCALE_SH screen pixels per texel; legal range 0..3.
- FRAME_HOLD, 8, frame_tick pulses per animation frame; must be ≥1.
- IDX_W, 4, palette index width.
- TRANSP_IDX, 0, palette index treated as transparent.
- ADDR_W, clog2(SPR_W*SPR_H*N_FRAMES), ROM address width (derived).

Ports:
- vga_clk  in  1  pixel clock.
- Reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video (same polarity as the existing sprite examples).
- frame_tick  in  1  one-cycle pulse per video frame (vsync edge).
- sprite_x  in  10  requested top-left column.
- sprite_y  in  10  requested top-left row.
- flip_h  in  1  mirror horizontally.
- flip_v  in  1  mirror vertically.
- anim_start  in  1  pulse: restart animation at frame 0.
- anim_stop  in  1  pulse: freeze on the current frame.
- one_shot  in  1  sampled at anim_start; 1 = play once then hold the last frame.
- rom_addr  out  ADDR_W  address to the external synchronous sprite ROM.
- rom_data  in  IDX_W  ROM read data, valid one cycle after rom_addr.
- pix_on  out  1  sprite covers this pixel and the texel is opaque.
- pix_index  out  IDX_W  palette index; 0 when pix_on=0.
- cur_frame  out  clog2(N_FRAMES)  current animation frame.
- anim_done  out  1  level; one-shot reached and is holding the last frame.

Behaviour:
- Reset:
  - All outputs 0.
  - Shadow position/flip registers 0.
  - FSM to IDLE; hold counter and frame to 0.
- Shadow registers:
  - sprite_x/y and flip_h/v are captured only on cycles with frame_tick=1.
  - Rendering always uses the shadow copies, so there is no mid-frame tearing.
- Pipeline: 3-cycle latency.
  - Edge 1: compute the following and register rom_addr, plus inbox/blank delay bits:
    - dx = DrawX − sx and dy = DrawY − sy, in 11-bit signed arithmetic.
    - inbox = 0 ≤ dx < SPR_W<<SCALE_SH and 0 ≤ dy < SPR_H<<SCALE_SH.
    - col = dx>>SCALE_SH, or SPR_W−1−col if flip_h.
    - row likewise with flip_v.
    - addr = cur_frame*SPR_W*SPR_H + row*SPR_W + col.
  - Edge 2: the ROM returns rom_data; inbox/blank delayed a second stage.
  - Edge 3: pix_on = inbox_d2 & blank_d2 & (rom_data ≠ TRANSP_IDX); pix_index = pix_on ? rom_data : 0.
  - When inbox = 0, rom_addr holds frame base (row=col=0); it is a don't-care for output.
- Boundary and edge cases:
  - Sprites partially off-screen (sx+width > 639) clip naturally.
  - Negative dx/dy give no coverage.
  - The last covered pixel is sx + (SPR_W<<SCALE_SH) − 1.
- Animation FSM:
  - IDLE: frame 0, anim_done 0. anim_start goes to PLAY with hold=0, frame=0, mode latched.
  - PLAY: each frame_tick increments hold. When hold == FRAME_HOLD−1 it clears and frame advances.
    - Loop mode: frame wraps N_FRAMES−1 → 0.
    - One-shot mode: reaching N_FRAMES−1 goes to DONE.
    - anim_stop goes to HOLD.
  - HOLD: frame frozen. anim_start restarts from frame 0 into PLAY.
  - DONE: frame = N_FRAMES−1, anim_done = 1. anim_start restarts.
- Simultaneous events:
  - anim_start and frame_tick together: start wins; hold=0, frame=0, no increment.
  - anim_start and anim_stop together: start wins.
- cur_frame changes only on frame_tick or anim_start cycles.
- Reset mid-animation or mid-line: everything returns to the reset state next edge; pipeline bits clear, so no spurious pix_on.
- N_FRAMES=1: frame stays 0; one-shot enters DONE on the first hold wrap.

Decomposition:
- Package sprite_pkg holds:
  - the anim_state_t enum {IDLE, PLAY, HOLD, DONE};
  - the addr_w(w,h,n) function;
  - the COORD_W=10 constant.
- One sub-module: sprite_anim_ctrl. It contains the FSM, hold counter, frame counter and anim_done, taking frame_tick/anim_start/anim_stop/one_shot.
- The address/pipeline datapath stays in sprite_blitter.

Test Plan:
- Bench setup: ROM model with 1-cycle latency; texel value = (addr mod 15)+1, except addr 0 = TRANSP_IDX.
- Position/latency:
  - Stimulus: sprite at (100,50) latched by frame_tick; sweep DrawX 98..126 on DrawY=50.
  - Required: pix_on rises exactly 3 cycles after DrawX=101 is presented and falls after DrawX=123. DrawX=100 (texel addr 0) yields pix_on=0 from transparency.
- Scaling/flip:
  - Stimulus: SCALE_SH=1, flip_h=1.
  - Required: DrawX=sx+0/+1 both address col 23; DrawX=sx+47 addresses col 0; coverage width is 48.
- Tearing guard:
  - Stimulus: change sprite_x mid-frame without frame_tick.
  - Required: rom_addr is unchanged until the next frame_tick.
- Loop animation:
  - Stimulus: FRAME_HOLD=2, N_FRAMES=4, anim_start, then 8 frame_ticks.
  - Required: cur_frame sequence 0,0,1,1,2,2,3,3,0; rom_addr base steps by 576.
- One-shot and stop:
  - Stimulus: one_shot=1.
  - Required: after 6 ticks, cur_frame=3 and anim_done=1, holding. anim_stop during PLAY freezes the frame. anim_start coincident with frame_tick gives frame 0.
- Reset:
  - Stimulus: assert Reset while pix_on=1 in PLAY frame 2.
  - Required: next edge pix_on=0, cur_frame=0, anim_done=0, rom_addr=0; pix_on stays 0 for 3 cycles after release.

Source files
------------

// File: rtl/sprite_blitter_pkg.sv
// Shared types and helpers for the sprite blitter slice.
// Holds the animation state enum, coordinate width and ROM address width helper.
// No logic here; imported by the interface, the top and the animation controller.
package sprite_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } anim_state_t;

    // Address width needed to cover w*h texels per frame times n frames.
    function automatic int addr_w(input int w, input int h, input int n);
        int a;
        a = $clog2(w * h * n);
        return (a < 1) ? 1 : a;
    endfunction

    // Frame counter width; never narrower than one bit so N_FRAMES=1 still has a port.
    function automatic int frame_w(input int n);
        int a;
        a = $clog2(n);
        return (a < 1) ? 1 : a;
    endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Pixel-stream, control and ROM signals of one sprite blitter instance.
// slave  = the blitter (consumes raster/control, drives ROM address and pixel outputs).
// master = the surrounding video pipeline and ROM; no backpressure, one pixel per clock.
interface sprite_blitter_if
    import sprite_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int ADDR_W  = 12,
    parameter int FRAME_W = 2
);
    logic [COORD_W-1:0] DrawX;
    logic [COORD_W-1:0] DrawY;
    logic               blank;
    logic               frame_tick;
    logic [COORD_W-1:0] sprite_x;
    logic [COORD_W-1:0] sprite_y;
    logic               flip_h;
    logic               flip_v;
    logic               anim_start;
    logic               anim_stop;
    logic               one_shot;
    logic [ADDR_W-1:0]  rom_addr;
    logic [IDX_W-1:0]   rom_data;
    logic               pix_on;
    logic [IDX_W-1:0]   pix_index;
    logic [FRAME_W-1:0] cur_frame;
    logic               anim_done;

    modport master (
        output DrawX, DrawY, blank, frame_tick, sprite_x, sprite_y,
               flip_h, flip_v, anim_start, anim_stop, one_shot, rom_data,
        input  rom_addr, pix_on, pix_index, cur_frame, anim_done
    );

    modport slave (
        input  DrawX, DrawY, blank, frame_tick, sprite_x, sprite_y,
               flip_h, flip_v, anim_start, anim_stop, one_shot, rom_data,
        output rom_addr, pix_on, pix_index, cur_frame, anim_done
    );
endinterface

// File: rtl/sprite_blitter_anim_ctrl.sv
// Animation sequencer: picks the sprite frame from frame_tick pulses (loop or one-shot).
// Latency: cur_frame/anim_done are registered, updated on the edge that samples the event.
// No backpressure; ports: clk, rst, frame_tick, anim_start, anim_stop, one_shot -> cur_frame, anim_done.
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int N_FRAMES   = 4,
    parameter int FRAME_HOLD = 8,
    parameter int FRAME_W    = frame_w(N_FRAMES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               anim_start,
    input  logic               anim_stop,
    input  logic               one_shot,
    output logic [FRAME_W-1:0] cur_frame,
    output logic               anim_done
);
    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(N_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);

    anim_state_t        state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               mode_q, mode_d;   // 1 = one-shot, latched at anim_start
    logic               done_q, done_d;
    logic [FRAME_W-1:0] frame_nxt;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        frame_d   = frame_q;
        mode_d    = mode_q;
        done_d    = done_q;
        frame_nxt = (frame_q == LAST_FRAME) ? '0 : frame_q + FRAME_W'(1);

        // anim_start overrides stop and any same-cycle tick.
        if (anim_start) begin
            state_d = PLAY;
            hold_d  = '0;
            frame_d = '0;
            mode_d  = one_shot;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (anim_stop) begin
                        state_d = HOLD;
                    end else if (frame_tick) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_d  = '0;
                            frame_d = frame_nxt;
                            // One-shot parks as soon as the last frame is shown.
                            if (mode_q && (frame_nxt == LAST_FRAME)) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            frame_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            frame_q <= frame_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign cur_frame = frame_q;
    assign anim_done = done_q;

endmodule

// File: rtl/sprite_blitter.sv
// Positioned, scaled, flippable, animated sprite renderer producing palette index + coverage.
// Latency: 3 vga_clk cycles from DrawX/DrawY to pix_on/pix_index (ROM read is the middle stage).
// No backpressure: one pixel per clock. Ports: vga_clk, Reset, vga (slave modport of sprite_blitter_if).
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 24,
    parameter int SPR_H      = 24,
    parameter int N_FRAMES   = 4,
    parameter int SCALE_SH   = 0,
    parameter int FRAME_HOLD = 8,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = 0,
    parameter int ADDR_W     = addr_w(SPR_W, SPR_H, N_FRAMES)
) (
    input  logic          vga_clk,
    input  logic          Reset,
    sprite_blitter_if.slave vga
);
    localparam int FRAME_W  = frame_w(N_FRAMES);
    localparam int FRAME_SZ = SPR_W * SPR_H;
    localparam logic [COORD_W-1:0] BOX_W = COORD_W'(SPR_W << SCALE_SH);
    localparam logic [COORD_W-1:0] BOX_H = COORD_W'(SPR_H << SCALE_SH);

    // Shadow copies: only reloaded on frame_tick so a frame is drawn with one position.
    logic [COORD_W-1:0] sx_q, sx_d, sy_q, sy_d;
    logic               fh_q, fh_d, fv_q, fv_d;

    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               inbox_d1_q, inbox_d1_d, blank_d1_q, blank_d1_d;
    logic               inbox_d2_q, inbox_d2_d, blank_d2_q, blank_d2_d;
    logic               pix_on_q, pix_on_d;
    logic [IDX_W-1:0]   pix_index_q, pix_index_d;

    logic [FRAME_W-1:0] frame;

    logic signed [COORD_W:0] dx, dy;
    logic               in_x, in_y, inbox;
    logic [COORD_W-1:0] col_raw, row_raw, col, row;

    sprite_anim_ctrl #(
        .N_FRAMES   (N_FRAMES),
        .FRAME_HOLD (FRAME_HOLD),
        .FRAME_W    (FRAME_W)
    ) u_anim (
        .clk        (vga_clk),
        .rst        (Reset),
        .frame_tick (vga.frame_tick),
        .anim_start (vga.anim_start),
        .anim_stop  (vga.anim_stop),
        .one_shot   (vga.one_shot),
        .cur_frame  (frame),
        .anim_done  (vga.anim_done)
    );

    always_comb begin
        sx_d = vga.frame_tick ? vga.sprite_x : sx_q;
        sy_d = vga.frame_tick ? vga.sprite_y : sy_q;
        fh_d = vga.frame_tick ? vga.flip_h   : fh_q;
        fv_d = vga.frame_tick ? vga.flip_v   : fv_q;

        // Zero-extended 11-bit signed difference: sign bit set means left/above the sprite.
        dx = $signed({1'b0, vga.DrawX}) - $signed({1'b0, sx_q});
        dy = $signed({1'b0, vga.DrawY}) - $signed({1'b0, sy_q});

        in_x  = ~dx[COORD_W] && (dx[COORD_W-1:0] < BOX_W);
        in_y  = ~dy[COORD_W] && (dy[COORD_W-1:0] < BOX_H);
        inbox = in_x && in_y;

        col_raw = dx[COORD_W-1:0] >> SCALE_SH;
        row_raw = dy[COORD_W-1:0] >> SCALE_SH;
        col     = fh_q ? (COORD_W'(SPR_W - 1) - col_raw) : col_raw;
        row     = fv_q ? (COORD_W'(SPR_H - 1) - row_raw) : row_raw;

        // Outside the box the address parks on the frame base.
        if (!inbox) begin
            col = '0;
            row = '0;
        end

        rom_addr_d = ADDR_W'(frame) * ADDR_W'(FRAME_SZ)
                   + ADDR_W'(row) * ADDR_W'(SPR_W)
                   + ADDR_W'(col);
        inbox_d1_d = inbox;
        blank_d1_d = vga.blank;

        inbox_d2_d = inbox_d1_q;
        blank_d2_d = blank_d1_q;

        pix_on_d    = inbox_d2_q && blank_d2_q && (vga.rom_data != IDX_W'(TRANSP_IDX));
        pix_index_d = pix_on_d ? vga.rom_data : '0;
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            sx_q        <= '0;
            sy_q        <= '0;
            fh_q        <= 1'b0;
            fv_q        <= 1'b0;
            rom_addr_q  <= '0;
            inbox_d1_q  <= 1'b0;
            blank_d1_q  <= 1'b0;
            inbox_d2_q  <= 1'b0;
            blank_d2_q  <= 1'b0;
            pix_on_q    <= 1'b0;
            pix_index_q <= '0;
        end else begin
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            fh_q        <= fh_d;
            fv_q        <= fv_d;
            rom_addr_q  <= rom_addr_d;
            inbox_d1_q  <= inbox_d1_d;
            blank_d1_q  <= blank_d1_d;
            inbox_d2_q  <= inbox_d2_d;
            blank_d2_q  <= blank_d2_d;
            pix_on_q    <= pix_on_d;
            pix_index_q <= pix_index_d;
        end
    end

    assign vga.rom_addr  = rom_addr_q;
    assign vga.pix_on    = pix_on_q;
    assign vga.pix_index = pix_index_q;
    assign vga.cur_frame = frame;

endmodule
